// File: rtl/prefetch_fifo_line_reader.sv
// rtl/prefetch_fifo_line_reader.sv - pops one line of words from the prefetch FIFO and emits it as a pixel stream
// Tracks line/frame position and reports FIFO underflow (fill-and-continue or stall).
module prefetch_fifo_line_reader #(
  parameter int unsigned                 c_DATA_WIDTH     = 16,
  parameter int unsigned                 c_H_ACTIVE       = 1920,
  parameter int unsigned                 c_V_ACTIVE       = 1080,
  parameter logic [c_DATA_WIDTH-1:0]     c_FILL_DATA      = '0,
  parameter int unsigned                 c_UNDERFLOW_MODE = 0,
  parameter int unsigned                 c_CNT_WIDTH      = 16
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  input  logic [c_DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                    fifo_rd_vld,
  output logic                    fifo_rd_en,
  input  logic                    frame_start,
  input  logic                    line_req,
  output logic                    pix_de,
  output logic [c_DATA_WIDTH-1:0] pix_data,
  output logic                    line_done,
  output logic                    frame_done,
  output logic [15:0]             line_cnt,
  output logic                    busy,
  output logic                    underflow,
  output logic                    req_overrun,
  output logic [c_CNT_WIDTH-1:0]  underflow_cnt
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [15:0] c_PIX_LAST  = 16'(c_H_ACTIVE - 1);
  localparam logic [15:0] c_LINE_LAST = 16'(c_V_ACTIVE - 1);

  state_t      state_q, state_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic        active, pop, uf_cycle, slot, last_slot;

  assign active    = (state_q == ACTIVE);
  assign pop       = active & fifo_rd_vld;
  assign uf_cycle  = active & ~fifo_rd_vld;
  // Mode 0 consumes a pixel slot every active cycle; mode 1 only on a real pop.
  assign slot      = (c_UNDERFLOW_MODE == 0) ? active : pop;
  assign last_slot = slot & (pix_cnt_q == c_PIX_LAST);

  // State is a flop, so these decodes are registered outputs.
  assign fifo_rd_en = active;
  assign busy       = active;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    if (frame_start) begin
      pix_cnt_d = '0;
      state_d   = line_req ? ACTIVE : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (line_req) begin
            state_d   = ACTIVE;
            pix_cnt_d = '0;
          end
        end
        ACTIVE: begin
          if (last_slot) begin
            state_d   = IDLE;
            pix_cnt_d = '0;
          end else if (slot) begin
            pix_cnt_d = pix_cnt_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      pix_de        <= 1'b0;
      pix_data      <= '0;
      line_done     <= 1'b0;
      frame_done    <= 1'b0;
      line_cnt      <= '0;
      underflow     <= 1'b0;
      req_overrun   <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      pix_de     <= slot & ~frame_start;
      line_done  <= last_slot & ~frame_start;
      frame_done <= last_slot & ~frame_start & (line_cnt == c_LINE_LAST);

      if (!frame_start && active) begin
        if (c_UNDERFLOW_MODE == 0)
          pix_data <= fifo_rd_vld ? fifo_rd_data : c_FILL_DATA;
        else if (pop)
          pix_data <= fifo_rd_data;
      end

      if (frame_start) begin
        line_cnt      <= '0;
        underflow     <= 1'b0;
        req_overrun   <= 1'b0;
        underflow_cnt <= '0;
      end else begin
        if (last_slot)
          line_cnt <= (line_cnt == c_LINE_LAST) ? 16'd0 : line_cnt + 16'd1;
        if (uf_cycle) begin
          underflow <= 1'b1;
          if (underflow_cnt != {c_CNT_WIDTH{1'b1}})
            underflow_cnt <= underflow_cnt + 1'b1;
        end
        if (line_req && active)
          req_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prefetch_fifo_line_reader.sv
// tb/tb_prefetch_fifo_line_reader.sv - scoreboard bench for prefetch_fifo_line_reader
// Two instances (fill mode and stall mode) share one FIFO model; sel picks the active one.
module tb_prefetch_fifo_line_reader;

  localparam int H = 8;
  localparam int V = 3;
  localparam logic [15:0] FILL = 16'h00EE;

  typedef struct {
    logic [15:0] d;
    logic        last;
    logic        frame;
  } exp_t;

  logic rd_clk = 1'b0;
  logic rd_rst = 1'b1;
  logic sel = 1'b0;
  logic line_req = 1'b0;
  logic frame_start = 1'b0;
  logic [15:0] stall_mask = '0;
  logic [15:0] mem [0:31];
  int wr_ptr = 0, rd_ptr = 0, cyc = 0, req_cyc = -100;
  logic stall, fifo_rd_vld;
  logic [15:0] fifo_rd_data;

  logic en0, de0, ld0, fd0, busy0, uf0, ro0;
  logic en1, de1, ld1, fd1, busy1, uf1, ro1;
  logic [15:0] data0, data1, lc0, lc1, uc0, uc1;

  always #5 rd_clk = ~rd_clk;

  wire en    = sel ? en1   : en0;
  wire de    = sel ? de1   : de0;
  wire ld    = sel ? ld1   : ld0;
  wire fd    = sel ? fd1   : fd0;
  wire bsy   = sel ? busy1 : busy0;
  wire uf    = sel ? uf1   : uf0;
  wire ro    = sel ? ro1   : ro0;
  wire [15:0] pdata = sel ? data1 : data0;
  wire [15:0] lcnt  = sel ? lc1   : lc0;
  wire [15:0] ucnt  = sel ? uc1   : uc0;

  always_comb begin
    stall = 1'b0;
    if ((cyc - req_cyc) >= 0 && (cyc - req_cyc) < 16)
      stall = stall_mask[4'(cyc - req_cyc)];
    fifo_rd_vld  = (wr_ptr != rd_ptr) && !stall;
    fifo_rd_data = mem[rd_ptr[4:0]];
  end

  always @(posedge rd_clk) begin
    cyc <= cyc + 1;
    if (en && fifo_rd_vld) rd_ptr <= rd_ptr + 1;
  end

  prefetch_fifo_line_reader #(
    .c_DATA_WIDTH(16), .c_H_ACTIVE(H), .c_V_ACTIVE(V), .c_FILL_DATA(FILL),
    .c_UNDERFLOW_MODE(0), .c_CNT_WIDTH(16)
  ) u_mode0 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld),
    .fifo_rd_en(en0), .frame_start(frame_start & ~sel), .line_req(line_req & ~sel),
    .pix_de(de0), .pix_data(data0), .line_done(ld0), .frame_done(fd0), .line_cnt(lc0),
    .busy(busy0), .underflow(uf0), .req_overrun(ro0), .underflow_cnt(uc0)
  );

  prefetch_fifo_line_reader #(
    .c_DATA_WIDTH(16), .c_H_ACTIVE(H), .c_V_ACTIVE(V), .c_FILL_DATA(FILL),
    .c_UNDERFLOW_MODE(1), .c_CNT_WIDTH(16)
  ) u_mode1 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld),
    .fifo_rd_en(en1), .frame_start(frame_start & sel), .line_req(line_req & sel),
    .pix_de(de1), .pix_data(data1), .line_done(ld1), .frame_done(fd1), .line_cnt(lc1),
    .busy(busy1), .underflow(uf1), .req_overrun(ro1), .underflow_cnt(uc1)
  );

  exp_t exp_q[$];
  exp_t e_mon;
  int checks = 0, errors = 0;
  int en_cnt, de_cnt, ld_cnt, fd_cnt, first_de, last_de, first_en;
  logic [15:0] de_hist;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[4:0]] = base + 16'(i);
      wr_ptr++;
    end
  endtask

  task automatic exp_pix(input logic [15:0] d, input logic last, input logic frame);
    exp_t x;
    x.d = d; x.last = last; x.frame = frame;
    exp_q.push_back(x);
  endtask

  task automatic exp_line(input logic [15:0] base, input logic frame);
    for (int i = 0; i < H; i++) exp_pix(base + 16'(i), i == H - 1, frame && (i == H - 1));
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
  endtask

  task automatic do_req();
    @(posedge rd_clk); #1 line_req = 1'b1;
    @(posedge rd_clk); #1 line_req = 1'b0;
    req_cyc = cyc;
    en_cnt = 0; de_cnt = 0; ld_cnt = 0; first_de = -1; last_de = -1; first_en = -1;
    de_hist = '0;
  endtask

  task automatic frame_sync();
    @(posedge rd_clk); #1 frame_start = 1'b1;
    @(posedge rd_clk); #1 frame_start = 1'b0;
    fd_cnt = 0;
    @(posedge rd_clk); #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((bsy || exp_q.size() != 0) && n < 60) begin
      @(posedge rd_clk); #1;
      n++;
    end
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL %s_timeout busy=%0b pending=%0d expected idle", name, bsy, exp_q.size());
    end
    repeat (2) @(posedge rd_clk);
    #1;
  endtask

  initial begin
    en_cnt = 0; de_cnt = 0; ld_cnt = 0; fd_cnt = 0;
    first_de = -1; last_de = -1; first_en = -1; de_hist = '0;

    fork
      forever begin
        @(negedge rd_clk);
        if (!rd_rst) begin
          if (en) begin
            en_cnt++;
            if (first_en < 0) first_en = cyc;
          end
          if (de) begin
            de_cnt++;
            if (first_de < 0) first_de = cyc;
            last_de = cyc;
            if ((cyc - req_cyc) >= 0 && (cyc - req_cyc) < 16) de_hist[4'(cyc - req_cyc)] = 1'b1;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_pix_de cyc=%0d data=%h expected no pixel", cyc, pdata);
            end else begin
              e_mon = exp_q.pop_front();
              if (pdata !== e_mon.d || ld !== e_mon.last || fd !== e_mon.frame) begin
                errors++;
                $display("FAIL pixel cyc=%0d got d=%h ld=%0b fd=%0b expected d=%h ld=%0b fd=%0b",
                         cyc, pdata, ld, fd, e_mon.d, e_mon.last, e_mon.frame);
              end
            end
          end else if (ld || fd) begin
            checks++; errors++;
            $display("FAIL stray_done cyc=%0d got ld=%0b fd=%0b expected 0", cyc, ld, fd);
          end
          if (ld) ld_cnt++;
          if (fd) fd_cnt++;
        end
      end
    join_none

    // reset state
    repeat (3) @(posedge rd_clk);
    #1;
    chk("rst_outputs", {en, de, ld, fd, bsy, uf, ro}, 0);
    chk("rst_pix_data", pdata, 0);
    chk("rst_line_cnt", lcnt, 0);
    chk("rst_ucnt", ucnt, 0);
    rd_rst = 1'b0;

    // 1: clean line, mode 0
    push_words(16'h10, 8); exp_line(16'h10, 0);
    do_req(); wait_idle("t1");
    chk("t1_first_en", first_en - req_cyc, 0);
    chk("t1_en_cnt", en_cnt, 8);
    chk("t1_first_de", first_de - req_cyc, 1);
    chk("t1_de_hist", de_hist, 16'h01FE);
    chk("t1_line_cnt", lcnt, 1);
    chk("t1_underflow", uf, 0);

    // 2: two-slot underflow, mode 0 fills
    frame_sync(); flush();
    stall_mask = 16'h0018;
    push_words(16'h10, 8);
    exp_pix(16'h10, 0, 0); exp_pix(16'h11, 0, 0); exp_pix(16'h12, 0, 0);
    exp_pix(FILL, 0, 0); exp_pix(FILL, 0, 0);
    exp_pix(16'h13, 0, 0); exp_pix(16'h14, 0, 0); exp_pix(16'h15, 1, 0);
    do_req(); wait_idle("t2");
    chk("t2_de_hist", de_hist, 16'h01FE);
    chk("t2_en_cnt", en_cnt, 8);
    chk("t2_ucnt", ucnt, 2);
    chk("t2_underflow", uf, 1);
    flush(); stall_mask = '0;

    // 3: same stall, mode 1 waits for data
    sel = 1'b1;
    frame_sync(); flush();
    stall_mask = 16'h0018;
    push_words(16'h10, 8); exp_line(16'h10, 0);
    do_req(); wait_idle("t3");
    chk("t3_de_hist", de_hist, 16'h07CE);
    chk("t3_en_cnt", en_cnt, 10);
    chk("t3_ucnt", ucnt, 2);
    chk("t3_line_cnt", lcnt, 1);
    stall_mask = '0;

    // 4: frame of three lines, mode 0
    sel = 1'b0;
    frame_sync(); flush();
    for (int l = 0; l < 3; l++) begin
      push_words(16'h30 + 16'(l * 16), 8);
      exp_line(16'h30 + 16'(l * 16), l == 2);
      do_req(); wait_idle("t4");
      chk("t4_line_cnt", lcnt, (l + 1) % 3);
      chk("t4_fd_cnt", fd_cnt, (l == 2) ? 1 : 0);
    end

    // 5: frame_start abandons a line mid-way
    frame_sync(); flush();
    stall_mask = 16'h0001;
    push_words(16'h60, 8);
    exp_pix(FILL, 0, 0); exp_pix(16'h60, 0, 0); exp_pix(16'h61, 0, 0);
    do_req();
    repeat (3) @(posedge rd_clk);
    #1 frame_start = 1'b1;
    @(posedge rd_clk); #1 frame_start = 1'b0;
    repeat (3) @(posedge rd_clk);
    #1;
    chk("t5_de_cnt", de_cnt, 3);
    chk("t5_ld_cnt", ld_cnt, 0);
    chk("t5_busy", bsy, 0);
    chk("t5_line_cnt", lcnt, 0);
    chk("t5_ucnt", ucnt, 0);
    chk("t5_underflow", uf, 0);
    flush(); stall_mask = '0;
    push_words(16'h70, 8); exp_line(16'h70, 0);
    do_req(); wait_idle("t5b");
    chk("t5b_en_cnt", en_cnt, 8);
    chk("t5b_line_cnt", lcnt, 1);

    // 6: overrun request ignored, then reset mid-line
    frame_sync(); flush();
    push_words(16'h80, 8); exp_line(16'h80, 0);
    do_req();
    repeat (3) @(posedge rd_clk);
    #1 line_req = 1'b1;
    @(posedge rd_clk); #1 line_req = 1'b0;
    wait_idle("t6");
    chk("t6_overrun", ro, 1);
    chk("t6_de_cnt", de_cnt, 8);
    chk("t6_en_cnt", en_cnt, 8);

    flush();
    push_words(16'h90, 8);
    exp_pix(16'h90, 0, 0); exp_pix(16'h91, 0, 0);
    do_req();
    repeat (3) @(posedge rd_clk);
    #2 rd_rst = 1'b1;
    #1;
    chk("t6_rst_outputs", {en, de, ld, fd, bsy, uf, ro}, 0);
    chk("t6_rst_pix_data", pdata, 0);
    chk("t6_rst_line_cnt", lcnt, 0);
    repeat (2) @(posedge rd_clk);
    #1 rd_rst = 1'b0;
    flush();
    repeat (6) @(posedge rd_clk);
    #1;
    chk("t6_post_rst_de_cnt", de_cnt, 2);
    chk("t6_post_rst_busy", bsy, 0);
    chk("t6_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached expected finish");
    $fatal(1);
  end

endmodule
